// File: rtl/bus_arbiter_pkg.sv
// Shared types and default timing constants for the CPU external bus arbiter.
package pa_cpu;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_HOLD,
        ST_DMA,
        ST_TURN
    } e_bus_arb_state;

    localparam int BUS_ARB_WS      = 1;
    localparam int BUS_ARB_DMA_MAX = 16;
    localparam int BUS_ARB_WAIT_TO = 255;

endpackage

// File: rtl/bus_arbiter_if.sv
// CPU request, DMA handshake and external pin bundle around the bus arbiter.
interface bus_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              cpu_req;
    logic              cpu_wr;
    logic              cpu_mem_io;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_halt;
    logic [7:0]        cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;
    logic              dma_req;
    logic              dma_ack;
    logic              pin_wait;
    logic [7:0]        data_bus_in;
    logic [ADDR_W-1:0] address_bus;
    logic [7:0]        data_bus_out;
    logic              data_oe;
    logic              bus_oe;
    logic              rd_n;
    logic              wr_n;
    logic              mem_io;

    // The arbiter itself
    modport master (
        input  cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata, cpu_halt,
        input  dma_req, pin_wait, data_bus_in,
        output cpu_rdata, cpu_done, cpu_err, dma_ack,
        output address_bus, data_bus_out, data_oe, bus_oe, rd_n, wr_n, mem_io
    );

    // CPU core, DMA master and pad ring seen from the other side
    modport slave (
        output cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata, cpu_halt,
        output dma_req, pin_wait, data_bus_in,
        input  cpu_rdata, cpu_done, cpu_err, dma_ack,
        input  address_bus, data_bus_out, data_oe, bus_oe, rd_n, wr_n, mem_io
    );

endinterface

// File: rtl/bus_arbiter.sv
// Sequences CPU bus cycles (addr / strobe+waits / hold) and grants the pins to
// an external DMA master with bounded tenure. Pin outputs follow the FSM by one clock.
module bus_arbiter
    import pa_cpu::*;
#(
    parameter int ADDR_W  = 22,
    parameter int WS      = BUS_ARB_WS,
    parameter int DMA_MAX = BUS_ARB_DMA_MAX,
    parameter int WAIT_TO = BUS_ARB_WAIT_TO
) (
    input  logic          clk,
    input  logic          arst,
    bus_arbiter_if.master bus
);

    localparam logic [3:0] WS_L      = 4'(WS);
    localparam logic [8:0] DMA_MAX_L = 9'(DMA_MAX);
    localparam logic [8:0] WAIT_TO_L = 9'(WAIT_TO);

    e_bus_arb_state    state_q, state_d;
    logic              last_cpu_q, last_cpu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              mem_io_q, mem_io_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [3:0]        ws_cnt_q, ws_cnt_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [7:0]        ten_cnt_q, ten_cnt_d;
    logic              abort_q, abort_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              bus_oe_q, bus_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              dma_ack_q, dma_ack_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_phase;

    assign cpu_phase = state_q inside {ST_ADDR, ST_STROBE, ST_HOLD};

    always_comb begin
        state_d    = state_q;
        last_cpu_d = last_cpu_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        mem_io_d   = mem_io_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ws_cnt_d   = ws_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ten_cnt_d  = ten_cnt_q;
        abort_d    = abort_q;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own the bus last wins
                if (bus.cpu_req && (!bus.dma_req || !last_cpu_q)) begin
                    addr_d   = bus.cpu_addr;
                    wr_d     = bus.cpu_wr;
                    mem_io_d = bus.cpu_mem_io;
                    wdata_d  = bus.cpu_wdata;
                    state_d  = ST_ADDR;
                end else if (bus.dma_req) begin
                    ten_cnt_d = 8'd0;
                    state_d   = ST_DMA;
                end
            end
            ST_ADDR: begin
                ws_cnt_d   = WS_L;
                wait_cnt_d = 8'd0;
                abort_d    = 1'b0;
                state_d    = ST_STROBE;
            end
            ST_STROBE: begin
                if (ws_cnt_q != 4'd0) begin
                    ws_cnt_d = ws_cnt_q - 4'd1;
                end
                if (bus.pin_wait) begin
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if ({1'b0, wait_cnt_q} + 9'd1 >= WAIT_TO_L) begin
                        abort_d = 1'b1;
                        rdata_d = bus.data_bus_in;
                        state_d = ST_HOLD;
                    end
                end else begin
                    wait_cnt_d = 8'd0;
                    if (ws_cnt_q == 4'd0) begin
                        rdata_d = bus.data_bus_in;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                last_cpu_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_DMA: begin
                last_cpu_d = 1'b0;
                if (!bus.dma_req) begin
                    state_d = ST_TURN;
                end else if (bus.cpu_req) begin
                    if (ten_cnt_q != 8'hFF) begin
                        ten_cnt_d = ten_cnt_q + 8'd1;
                    end
                    if ({1'b0, ten_cnt_q} + 9'd1 >= DMA_MAX_L) begin
                        state_d = ST_TURN;
                    end
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins decode the current state; bus_oe also drops early on a DMA grant so
    // the address drivers are off a full cycle before dma_ack rises.
    always_comb begin
        rd_n_d    = !(state_q == ST_STROBE && !wr_q);
        wr_n_d    = !(state_q == ST_STROBE && wr_q);
        data_oe_d = cpu_phase && wr_q;
        bus_oe_d  = cpu_phase ||
                    (state_q == ST_IDLE && !bus.cpu_halt && state_d != ST_DMA);
        dma_ack_d = (state_q == ST_DMA);
        done_d    = (state_q == ST_HOLD);
        err_d     = (state_q == ST_HOLD) && abort_q;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            last_cpu_q <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            mem_io_q   <= 1'b1;
            wdata_q    <= 8'd0;
            rdata_q    <= 8'd0;
            ws_cnt_q   <= 4'd0;
            wait_cnt_q <= 8'd0;
            ten_cnt_q  <= 8'd0;
            abort_q    <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            bus_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_cpu_q <= last_cpu_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            mem_io_q   <= mem_io_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ws_cnt_q   <= ws_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ten_cnt_q  <= ten_cnt_d;
            abort_q    <= abort_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            bus_oe_q   <= bus_oe_d;
            data_oe_q  <= data_oe_d;
            dma_ack_q  <= dma_ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.address_bus  = addr_q;
    assign bus.data_bus_out = wdata_q;
    assign bus.mem_io       = mem_io_q;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.rd_n         = rd_n_q;
    assign bus.wr_n         = wr_n_q;
    assign bus.bus_oe       = bus_oe_q;
    assign bus.data_oe      = data_oe_q;
    assign bus.dma_ack      = dma_ack_q;
    assign bus.cpu_done     = done_q;
    assign bus.cpu_err      = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: WS=1, DMA_MAX=4, WAIT_TO=8; outputs sampled on negedge.
module tb_bus_arbiter;

    localparam int AW = 22;

    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(AW)) bus ();

    bus_arbiter #(.ADDR_W(AW), .WS(1), .DMA_MAX(4), .WAIT_TO(8)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       chk_rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic drive_req(input logic wr, input logic mio, input logic [AW-1:0] a,
                             input logic [7:0] wd);
        bus.cpu_wr     = wr;
        bus.cpu_mem_io = mio;
        bus.cpu_addr   = a;
        bus.cpu_wdata  = wd;
        bus.cpu_req    = 1'b1;
    endtask

    // Watches one CPU cycle from the request; pin_wait is high for samples [pw_from, pw_to)
    task automatic mon_cycle(input int pw_from, input int pw_to, input int max_cyc,
                             output int lat, output int rd_lo, output int wr_lo,
                             output int doe_cnt, output logic mio, output logic [7:0] rdata,
                             output logic err, output bit tmo);
        lat = 0; rd_lo = 0; wr_lo = 0; doe_cnt = 0; mio = 1'bx; rdata = 8'hxx; err = 1'bx; tmo = 1'b1;
        bus.pin_wait = (pw_from <= 0 && pw_to > 0);
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (!bus.rd_n) rd_lo++;
            if (!bus.wr_n) wr_lo++;
            if (!bus.rd_n || !bus.wr_n) mio = bus.mem_io;
            if (bus.data_oe) doe_cnt++;
            bus.pin_wait = (k >= pw_from && k < pw_to);
            if (bus.cpu_done) begin
                lat = k; rdata = bus.cpu_rdata; err = bus.cpu_err; tmo = 1'b0;
                bus.cpu_req = 1'b0;
                bus.pin_wait = 1'b0;
                break;
            end
        end
        bus.pin_wait = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.rd_n !== 1'b1 || bus.wr_n !== 1'b1) $display("FAIL reset_strobes got rd_n=%b wr_n=%b want 1/1", bus.rd_n, bus.wr_n); else passes++;
        checks++; if ({bus.bus_oe, bus.data_oe, bus.dma_ack, bus.cpu_done, bus.cpu_err} !== 5'b0) $display("FAIL reset_ctrl got oe=%b doe=%b ack=%b done=%b err=%b want all 0", bus.bus_oe, bus.data_oe, bus.dma_ack, bus.cpu_done, bus.cpu_err); else passes++;
        checks++; if (bus.address_bus !== '0 || bus.data_bus_out !== 8'h00 || bus.cpu_rdata !== 8'h00) $display("FAIL reset_data got addr=%h dout=%h rdata=%h want 0", bus.address_bus, bus.data_bus_out, bus.cpu_rdata); else passes++;
        checks++; if (bus.mem_io !== 1'b1) $display("FAIL reset_mem_io got %b want 1", bus.mem_io); else passes++;
        arst = 1'b1;
        @(negedge clk);
        checks++; if (bus.bus_oe !== 1'b1 || bus.rd_n !== 1'b1) $display("FAIL idle_bus_oe got oe=%b rd_n=%b want 1/1", bus.bus_oe, bus.rd_n); else passes++;
        $display("reset: checked reset values and idle ownership");
    endtask

    task automatic test_read();
        int lat, rdl, wrl, doe; logic mio, err; logic [7:0] rd; bit tmo; exp_t e;
        @(negedge clk);
        bus.data_bus_in = 8'hA5;
        drive_req(1'b0, 1'b1, 22'h012345, 8'h00);
        exp_q.push_back('{8'hA5, 1'b1, 1'b0});
        mon_cycle(0, 0, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo) $display("FAIL read_timeout no cpu_done within 30 cycles"); else passes++;
        checks++; if (lat !== 5) $display("FAIL read_latency got %0d want 5", lat); else passes++;
        checks++; if (rdl !== 2 || wrl !== 0) $display("FAIL read_strobe got rd_lo=%0d wr_lo=%0d want 2/0", rdl, wrl); else passes++;
        checks++; if (rd !== e.rdata || err !== e.err) $display("FAIL read_data got %h err=%b want %h err=%b", rd, err, e.rdata, e.err); else passes++;
        checks++; if (bus.address_bus !== 22'h012345 || mio !== 1'b1) $display("FAIL read_addr got %h mem_io=%b want 012345/1", bus.address_bus, mio); else passes++;
        $display("read: addr=012345 rdata=%h lat=%0d rd_lo=%0d", rd, lat, rdl);
    endtask

    task automatic test_write_wait();
        int lat, rdl, wrl, doe; logic mio, err; logic [7:0] rd; bit tmo; exp_t e;
        @(negedge clk);
        bus.data_bus_in = 8'hFF;
        drive_req(1'b1, 1'b0, 22'h000010, 8'h3C);
        exp_q.push_back('{8'h00, 1'b0, 1'b0});
        mon_cycle(3, 6, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo) $display("FAIL write_timeout no cpu_done within 30 cycles"); else passes++;
        checks++; if (wrl !== 5 || rdl !== 0) $display("FAIL write_strobe got wr_lo=%0d rd_lo=%0d want 5/0", wrl, rdl); else passes++;
        checks++; if (mio !== 1'b0 || bus.data_bus_out !== 8'h3C) $display("FAIL write_io got mem_io=%b dout=%h want 0/3c", mio, bus.data_bus_out); else passes++;
        checks++; if (doe !== 7 || bus.data_oe !== 1'b1) $display("FAIL write_data_oe got cycles=%0d at_hold=%b want 7/1", doe, bus.data_oe); else passes++;
        checks++; if (err !== e.err || lat !== 8) $display("FAIL write_done got err=%b lat=%0d want %b/8", err, lat, e.err); else passes++;
        @(negedge clk);
        checks++; if (bus.data_oe !== 1'b0 || bus.cpu_done !== 1'b0) $display("FAIL write_after got data_oe=%b done=%b want 0/0", bus.data_oe, bus.cpu_done); else passes++;
        $display("write: io addr=0010 data=3c wr_lo=%0d lat=%0d", wrl, lat);
    endtask

    task automatic test_abort();
        int lat, rdl, wrl, doe; logic mio, err; logic [7:0] rd; bit tmo; exp_t e;
        @(negedge clk);
        bus.data_bus_in = 8'h5A;
        drive_req(1'b0, 1'b1, 22'h0ABCDE, 8'h00);
        exp_q.push_back('{8'h5A, 1'b1, 1'b1});
        mon_cycle(0, 1000, 40, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo) $display("FAIL abort_timeout no cpu_done within 40 cycles"); else passes++;
        checks++; if (rdl !== 8) $display("FAIL abort_strobe got rd_lo=%0d want 8", rdl); else passes++;
        checks++; if (err !== e.err || rd !== e.rdata) $display("FAIL abort_err got err=%b rdata=%h want %b/%h", err, rd, e.err, e.rdata); else passes++;
        @(negedge clk);
        checks++; if (bus.cpu_done !== 1'b0 || bus.cpu_err !== 1'b0) $display("FAIL abort_pulse got done=%b err=%b want 0/0", bus.cpu_done, bus.cpu_err); else passes++;
        $display("abort: rd_lo=%0d err=%b lat=%0d", rdl, err, lat);
    endtask

    task automatic test_back_to_back();
        int lat, rdl, wrl, doe; logic mio, err; logic [7:0] rd; bit tmo; exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.data_bus_in = (i == 0) ? 8'h11 : 8'h22;
            drive_req(1'b0, 1'b1, 22'(32'h200 + i), 8'h00);
            exp_q.push_back('{bus.data_bus_in, 1'b1, 1'b0});
            mon_cycle(0, 0, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
            e = exp_q.pop_front();
            checks++; if (tmo || lat !== 5) $display("FAIL b2b_latency_%0d got %0d tmo=%b want 5", i, lat, tmo); else passes++;
            checks++; if (rd !== e.rdata) $display("FAIL b2b_data_%0d got %h want %h", i, rd, e.rdata); else passes++;
            $display("b2b: transfer %0d rdata=%h lat=%0d", i, rd, lat);
        end
    endtask

    task automatic test_dma();
        int lat, rdl, wrl, doe, n_ack; logic mio, err, prev_oe; logic [7:0] rd; bit tmo, got; exp_t e;
        pulse_reset();
        bus.dma_req = 1'b1;
        bus.data_bus_in = 8'h77;
        drive_req(1'b0, 1'b1, 22'h000100, 8'h00);
        exp_q.push_back('{8'h77, 1'b1, 1'b0});
        mon_cycle(0, 0, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo || lat !== 5 || rd !== e.rdata) $display("FAIL dma_cpu_first got lat=%0d rdata=%h tmo=%b want 5/%h", lat, rd, tmo, e.rdata); else passes++;
        prev_oe = bus.bus_oe; got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.dma_ack) begin got = 1'b1; break; end
            prev_oe = bus.bus_oe;
        end
        checks++; if (!got) $display("FAIL dma_grant got dma_ack=0 want 1 within 10 cycles"); else passes++;
        checks++; if (prev_oe !== 1'b0 || bus.bus_oe !== 1'b0) $display("FAIL dma_turnaround got oe_before=%b oe_during=%b want 0/0", prev_oe, bus.bus_oe); else passes++;
        bus.data_bus_in = 8'h99;
        drive_req(1'b0, 1'b1, 22'h000300, 8'h00);
        exp_q.push_back('{8'h99, 1'b1, 1'b0});
        n_ack = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dma_ack) n_ack++; else break;
        end
        checks++; if (n_ack !== 4) $display("FAIL dma_tenure got %0d want 4", n_ack); else passes++;
        checks++; if (bus.bus_oe !== 1'b0 || bus.dma_ack !== 1'b0) $display("FAIL dma_turn got oe=%b ack=%b want 0/0", bus.bus_oe, bus.dma_ack); else passes++;
        @(negedge clk);
        checks++; if (bus.bus_oe !== 1'b1) $display("FAIL dma_turn_len got oe=%b want 1", bus.bus_oe); else passes++;
        mon_cycle(0, 0, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo || rd !== e.rdata || err !== e.err) $display("FAIL dma_cpu_after got rdata=%h err=%b tmo=%b want %h/0", rd, err, tmo, e.rdata); else passes++;
        bus.dma_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.dma_ack) begin got = 1'b1; break; end
        end
        checks++; if (!got) $display("FAIL dma_release got dma_ack=1 want 0 within 10 cycles"); else passes++;
        $display("dma: tenure=%0d cycles, cpu rdata after=%h", n_ack, rd);
    endtask

    task automatic test_reset_mid();
        int lat, rdl, wrl, doe, n_done; logic mio, err; logic [7:0] rd; bit tmo; exp_t e;
        @(negedge clk);
        bus.data_bus_in = 8'hC3;
        drive_req(1'b0, 1'b1, 22'h000400, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (bus.rd_n !== 1'b0) $display("FAIL mid_strobe got rd_n=%b want 0", bus.rd_n); else passes++;
        #2 arst = 1'b0;
        #1;
        checks++; if (bus.rd_n !== 1'b1 || bus.bus_oe !== 1'b0 || bus.cpu_done !== 1'b0) $display("FAIL mid_async got rd_n=%b oe=%b done=%b want 1/0/0", bus.rd_n, bus.bus_oe, bus.cpu_done); else passes++;
        bus.cpu_req = 1'b0;
        n_done = 0;
        repeat (2) @(negedge clk);
        arst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.cpu_done) n_done++;
        end
        checks++; if (n_done !== 0) $display("FAIL mid_no_done got %0d pulses want 0", n_done); else passes++;
        bus.data_bus_in = 8'h3E;
        drive_req(1'b0, 1'b1, 22'h000404, 8'h00);
        exp_q.push_back('{8'h3E, 1'b1, 1'b0});
        mon_cycle(0, 0, 30, lat, rdl, wrl, doe, mio, rd, err, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo || lat !== 5 || rd !== e.rdata) $display("FAIL mid_recover got lat=%0d rdata=%h tmo=%b want 5/%h", lat, rd, tmo, e.rdata); else passes++;
        $display("reset_mid: recovered read rdata=%h lat=%0d", rd, lat);
    endtask

    task automatic test_halt();
        bit got;
        @(negedge clk);
        bus.cpu_halt = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.bus_oe !== 1'b0) $display("FAIL halt_bus_oe got %b want 0", bus.bus_oe); else passes++;
        bus.dma_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.dma_ack) begin got = 1'b1; break; end
        end
        checks++; if (!got) $display("FAIL halt_dma_grant got dma_ack=0 want 1 within 5 cycles"); else passes++;
        bus.dma_req = 1'b0;
        bus.cpu_halt = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.dma_ack !== 1'b0 || bus.bus_oe !== 1'b1) $display("FAIL halt_release got ack=%b oe=%b want 0/1", bus.dma_ack, bus.bus_oe); else passes++;
        $display("halt: bus released while idle, dma granted");
    endtask

    initial begin
        bus.cpu_req     = 1'b0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_mem_io  = 1'b1;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = 8'h00;
        bus.cpu_halt    = 1'b0;
        bus.dma_req     = 1'b0;
        bus.pin_wait    = 1'b0;
        bus.data_bus_in = 8'h00;
        test_reset();
        test_read();
        test_write_wait();
        test_abort();
        test_back_to_back();
        test_dma();
        test_reset_mid();
        test_halt();
        checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
